// File: rtl/uart_regs_frac_pkg.sv
// Shared types and constants for the fractional-baud UART register bank.
// Holds the CSR struct, the address map, the IIR codes and the RX trigger-level helper.
package uart_pkg;

  typedef struct packed {
    logic [7:0] lcr;
    logic [3:0] ier;
    logic [2:0] fcr;   // {trigger code[1:0], fifo enable}
    logic [7:0] scr;
    logic [7:0] dll;
    logic [7:0] dlm;
    logic [7:0] dlf;
  } csr_t;

  localparam logic [3:0] ADDR_RBR_THR    = 4'd0;
  localparam logic [3:0] ADDR_IER        = 4'd1;
  localparam logic [3:0] ADDR_IIR_FCR    = 4'd2;
  localparam logic [3:0] ADDR_LCR        = 4'd3;
  localparam logic [3:0] ADDR_LSR        = 4'd5;
  localparam logic [3:0] ADDR_SCR        = 4'd7;
  localparam logic [3:0] ADDR_DLF        = 4'd8;
  localparam logic [3:0] ADDR_LSR_MIRROR = 4'd9;

  localparam logic [3:0] IIR_NONE = 4'h1;
  localparam logic [3:0] IIR_THRE = 4'h2;
  localparam logic [3:0] IIR_RXDA = 4'h4;
  localparam logic [3:0] IIR_RLS  = 4'h6;

  function automatic int unsigned thresh(input logic [1:0] code, input int unsigned depth);
    int unsigned t;
    case (code)
      2'd0:    t = 1;
      2'd1:    t = depth / 4;
      2'd2:    t = depth / 2;
      default: t = depth - 2;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_regs_frac_if.sv
// Host register bus: one-cycle read/write strobes, 4-bit address, registered read data.
interface uart_regs_frac_if;
  logic       wr_i;
  logic       rd_i;
  logic [3:0] addr_i;
  logic [7:0] din_i;
  logic [7:0] dout_o;

  modport master (output wr_i, output rd_i, output addr_i, output din_i, input dout_o);
  modport slave  (input wr_i, input rd_i, input addr_i, input din_i, output dout_o);
endinterface

// File: rtl/uart_regs_frac_baud.sv
// Fractional baud tick generator: periods of Dv cycles, stretched by one cycle whenever
// the FRAC_W-bit phase accumulator carries.
module uart_baud_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              baud_o
);

  localparam int LW = DIV_W + 1;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
  logic [LW-1:0]     last_cnt;
  logic              tick;

  always_comb begin
    // The carry of acc+F decides whether the period now running gets the extra cycle.
    acc_sum  = {1'b0, acc_q} + {1'b0, frac_i};
    last_cnt = {1'b0, div_i} - LW'(1) + LW'(acc_sum[FRAC_W]);
    tick     = (div_i != '0) && ({1'b0, cnt_q} == last_cnt);
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (div_i != '0) begin
      if (tick) begin
        cnt_d = '0;
        acc_d = acc_sum[FRAC_W-1:0];
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign baud_o = tick;

endmodule

// File: rtl/uart_regs_frac.sv
// 16550-style CSR bank with fractional baud divisor, prioritised IIR/irq and
// an extended window (DLF at 8, non-clearing LSR mirror at 9).
module uart_regs_frac
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_regs_frac_if.slave               bus,
  input  logic [7:0]                    rx_fifo_in,
  input  logic                          rx_fifo_empty_i,
  input  logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count_i,
  input  logic                          tx_fifo_empty_i,
  input  logic                          tx_idle_i,
  input  logic                          rx_oe,
  input  logic                          rx_pe,
  input  logic                          rx_fe,
  input  logic                          rx_bi,
  output logic                          tx_push_o,
  output logic                          rx_pop_o,
  output logic                          baud_out,
  output logic                          tx_rst,
  output logic                          rx_rst,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_threshold,
  output logic [7:0]                    lcr_o,
  output logic                          irq_o
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] DLM_MASK = 8'((1 << (DIV_W - 8)) - 1);
  localparam logic [7:0] DLF_MASK = 8'((1 << FRAC_W) - 1);

  csr_t       csr_q, csr_d;
  logic [3:0] sticky_q, sticky_d;
  logic       armed_q, armed_d;
  logic       tx_empty_prev_q;
  logic [7:0] dout_q, dout_d;
  logic       irq_q, irq_d;
  logic       rx_rst_q, rx_rst_d;
  logic       tx_rst_q, tx_rst_d;

  logic          dlab;
  logic [3:0]    errs;
  logic          lsr_clr;
  logic [7:0]    lsr;
  logic [CW-1:0] threshold;
  logic [3:0]    iir_code;
  logic [7:0]    iir;
  logic [7:0]    rdata;
  logic          thr_wr;
  logic          rbr_rd;
  logic          div_wr;

  assign dlab      = csr_q.lcr[7];
  assign errs      = {rx_bi, rx_fe, rx_pe, rx_oe};
  assign lsr_clr   = bus.rd_i && (bus.addr_i == ADDR_LSR);
  assign threshold = CW'(thresh(csr_q.fcr[2:1], FIFO_DEPTH));
  assign lsr       = {|sticky_q, tx_fifo_empty_i & tx_idle_i, tx_fifo_empty_i, sticky_q, ~rx_fifo_empty_i};

  // A pulse coinciding with a clearing read survives into the next cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sticky
    assign sticky_d[gi] = (sticky_q[gi] & ~lsr_clr) | errs[gi];
  end

  always_comb begin
    if (csr_q.ier[2] && (|sticky_q)) begin
      iir_code = IIR_RLS;
    end else if (csr_q.ier[0] && (rx_fifo_count_i >= threshold)) begin
      iir_code = IIR_RXDA;
    end else if (csr_q.ier[1] && armed_q) begin
      iir_code = IIR_THRE;
    end else begin
      iir_code = IIR_NONE;
    end
    iir = {{2{csr_q.fcr[0]}}, 2'b00, iir_code};
  end

  always_comb begin
    thr_wr = bus.wr_i && (bus.addr_i == ADDR_RBR_THR) && !dlab;
    rbr_rd = bus.rd_i && (bus.addr_i == ADDR_RBR_THR) && !dlab;
    div_wr = bus.wr_i && ((((bus.addr_i == ADDR_RBR_THR) || (bus.addr_i == ADDR_IER)) && dlab)
                          || (bus.addr_i == ADDR_DLF));

    case (bus.addr_i)
      ADDR_RBR_THR:    rdata = dlab ? csr_q.dll : (rx_fifo_empty_i ? 8'h00 : rx_fifo_in);
      ADDR_IER:        rdata = dlab ? csr_q.dlm : {4'h0, csr_q.ier};
      ADDR_IIR_FCR:    rdata = iir;
      ADDR_LCR:        rdata = csr_q.lcr;
      ADDR_LSR:        rdata = lsr;
      ADDR_SCR:        rdata = csr_q.scr;
      ADDR_DLF:        rdata = csr_q.dlf;
      ADDR_LSR_MIRROR: rdata = lsr;
      default:         rdata = 8'h00;
    endcase

    csr_d    = csr_q;
    rx_rst_d = 1'b0;
    tx_rst_d = 1'b0;
    if (bus.wr_i) begin
      case (bus.addr_i)
        ADDR_RBR_THR: if (dlab) csr_d.dll = bus.din_i;
        ADDR_IER: begin
          if (dlab) csr_d.dlm = bus.din_i & DLM_MASK;
          else      csr_d.ier = bus.din_i[3:0];
        end
        ADDR_IIR_FCR: begin
          csr_d.fcr = {bus.din_i[7:6], bus.din_i[0]};
          rx_rst_d  = bus.din_i[1];
          tx_rst_d  = bus.din_i[2];
        end
        ADDR_LCR: csr_d.lcr = bus.din_i;
        ADDR_SCR: csr_d.scr = bus.din_i;
        ADDR_DLF: csr_d.dlf = bus.din_i & DLF_MASK;
        default: ;
      endcase
    end

    // THRE arming: clearing events win over a same-cycle set.
    armed_d = armed_q;
    if (tx_fifo_empty_i && !tx_empty_prev_q) armed_d = 1'b1;
    if (bus.wr_i && !dlab && (bus.addr_i == ADDR_IER) && bus.din_i[1] && !csr_q.ier[1]
        && tx_fifo_empty_i) armed_d = 1'b1;
    if (thr_wr) armed_d = 1'b0;
    if (bus.rd_i && (bus.addr_i == ADDR_IIR_FCR) && (iir_code == IIR_THRE)) armed_d = 1'b0;

    dout_d = bus.rd_i ? rdata : dout_q;
    irq_d  = (iir_code != IIR_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_q           <= '0;
      csr_q.lcr       <= 8'h03;
      sticky_q        <= '0;
      armed_q         <= 1'b0;
      tx_empty_prev_q <= 1'b0;
      dout_q          <= 8'h00;
      irq_q           <= 1'b0;
      rx_rst_q        <= 1'b0;
      tx_rst_q        <= 1'b0;
    end else begin
      csr_q           <= csr_d;
      sticky_q        <= sticky_d;
      armed_q         <= armed_d;
      tx_empty_prev_q <= tx_fifo_empty_i;
      dout_q          <= dout_d;
      irq_q           <= irq_d;
      rx_rst_q        <= rx_rst_d;
      tx_rst_q        <= tx_rst_d;
    end
  end

  uart_baud_frac #(
    .DIV_W (DIV_W),
    .FRAC_W(FRAC_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (div_wr),
    .div_i ({csr_q.dlm[DIV_W-9:0], csr_q.dll}),
    .frac_i(csr_q.dlf[FRAC_W-1:0]),
    .baud_o(baud_out)
  );

  // Push/pop strobes line up with the host strobe so din_i / rx_fifo_in are valid alongside them.
  assign tx_push_o         = thr_wr;
  assign rx_pop_o          = rbr_rd && !rx_fifo_empty_i;
  assign bus.dout_o        = dout_q;
  assign tx_rst            = tx_rst_q;
  assign rx_rst            = rx_rst_q;
  assign rx_fifo_threshold = threshold;
  assign lcr_o             = csr_q.lcr;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_uart_regs_frac.sv
// Randomised bench for uart_regs_frac against a register-level reference model
// derived from the 16550 rules (map, LSR/IIR composition, fractional baud arithmetic).
module tb_uart_regs_frac;

  localparam int D      = 16;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int CW     = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_regs_frac_if bus();

  logic [7:0]    rx_fifo_in      = 8'h00;
  logic          rx_fifo_empty_i = 1'b1;
  logic [CW-1:0] rx_fifo_count_i = '0;
  logic          tx_fifo_empty_i = 1'b0;
  logic          tx_idle_i       = 1'b0;
  logic          rx_oe = 1'b0, rx_pe = 1'b0, rx_fe = 1'b0, rx_bi = 1'b0;
  logic          tx_push_o, rx_pop_o, baud_out, tx_rst, rx_rst, irq_o;
  logic [CW-1:0] rx_fifo_threshold;
  logic [7:0]    lcr_o;

  uart_regs_frac #(.FIFO_DEPTH(D), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rx_fifo_in(rx_fifo_in), .rx_fifo_empty_i(rx_fifo_empty_i), .rx_fifo_count_i(rx_fifo_count_i),
    .tx_fifo_empty_i(tx_fifo_empty_i), .tx_idle_i(tx_idle_i),
    .rx_oe(rx_oe), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o), .baud_out(baud_out),
    .tx_rst(tx_rst), .rx_rst(rx_rst), .rx_fifo_threshold(rx_fifo_threshold),
    .lcr_o(lcr_o), .irq_o(irq_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_lcr, m_scr, m_dll, m_dlm, m_dlf, m_fcr;
  logic [3:0] m_ier, m_sticky;
  logic       m_armed;
  logic       seen_push;

  function automatic void model_reset();
    m_lcr = 8'h03; m_scr = 8'h00; m_dll = 8'h00; m_dlm = 8'h00; m_dlf = 8'h00;
    m_fcr = 8'h00; m_ier = 4'h0; m_sticky = 4'h0; m_armed = 1'b0;
  endfunction

  function automatic int m_thresh();
    int t;
    case (m_fcr[7:6])
      2'd0: t = 1;
      2'd1: t = D / 4;
      2'd2: t = D / 2;
      default: t = D - 2;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] m_iir();
    logic [3:0] c;
    if (m_ier[2] && m_sticky != 4'h0) c = 4'h6;
    else if (m_ier[0] && int'(rx_fifo_count_i) >= m_thresh()) c = 4'h4;
    else if (m_ier[1] && m_armed) c = 4'h2;
    else c = 4'h1;
    return {{2{m_fcr[0]}}, 2'b00, c};
  endfunction

  function automatic logic [7:0] m_lsr();
    return {|m_sticky, tx_fifo_empty_i & tx_idle_i, tx_fifo_empty_i, m_sticky, ~rx_fifo_empty_i};
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [7:0] v;
    case (a)
      4'd0: v = m_lcr[7] ? m_dll : (rx_fifo_empty_i ? 8'h00 : rx_fifo_in);
      4'd1: v = m_lcr[7] ? m_dlm : {4'h0, m_ier};
      4'd2: v = m_iir();
      4'd3: v = m_lcr;
      4'd5, 4'd9: v = m_lsr();
      4'd7: v = m_scr;
      4'd8: v = m_dlf;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'd0: if (m_lcr[7]) m_dll = d; else m_armed = 1'b0;
      4'd1: begin
        if (m_lcr[7]) m_dlm = d;
        else begin
          if (d[1] && !m_ier[1] && tx_fifo_empty_i) m_armed = 1'b1;
          m_ier = d[3:0];
        end
      end
      4'd2: m_fcr = {d[7:6], 5'b0, d[0]};
      4'd3: m_lcr = d;
      4'd7: m_scr = d;
      4'd8: m_dlf = {4'h0, d[3:0]};
      default: ;
    endcase
  endfunction

  function automatic void model_after_read(input logic [3:0] a, input logic [3:0] err, input logic [7:0] rv);
    if (a == 4'd5) m_sticky = err;
    else m_sticky = m_sticky | err;
    if (a == 4'd2 && rv[3:0] == 4'h2) m_armed = 1'b0;
  endfunction

  // Host tasks start and end 1 time unit after a rising edge.
  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_i = 1'b1; bus.addr_i = a; bus.din_i = d;
    @(negedge clk);
    seen_push = tx_push_o;
    @(posedge clk); #1;
    bus.wr_i = 1'b0;
    model_write(a, d);
    $display("wr  addr=%0d data=%02h", a, d);
  endtask

  task automatic host_read(input logic [3:0] a, input logic [3:0] err,
                           output logic [7:0] d, output logic pop, output logic [7:0] exp);
    exp = m_read(a);
    bus.rd_i = 1'b1; bus.addr_i = a;
    {rx_bi, rx_fe, rx_pe, rx_oe} = err;
    @(negedge clk);
    pop = rx_pop_o;
    @(posedge clk); #1;
    bus.rd_i = 1'b0;
    {rx_bi, rx_fe, rx_pe, rx_oe} = 4'h0;
    d = bus.dout_o;
    model_after_read(a, err, exp);
    $display("rd  addr=%0d data=%02h exp=%02h", a, d, exp);
  endtask

  task automatic host_rw(input logic [3:0] a, input logic [7:0] wd,
                         output logic [7:0] d, output logic [7:0] exp);
    exp = m_read(a);
    bus.rd_i = 1'b1; bus.wr_i = 1'b1; bus.addr_i = a; bus.din_i = wd;
    @(posedge clk); #1;
    bus.rd_i = 1'b0; bus.wr_i = 1'b0;
    d = bus.dout_o;
    model_write(a, wd);
    model_after_read(a, 4'h0, exp);
    $display("rw  addr=%0d wdata=%02h rdata=%02h", a, wd, d);
  endtask

  task automatic pulse_err(input logic [3:0] err);
    {rx_bi, rx_fe, rx_pe, rx_oe} = err;
    @(posedge clk); #1;
    {rx_bi, rx_fe, rx_pe, rx_oe} = 4'h0;
    m_sticky = m_sticky | err;
    $display("err pulse=%b", err);
  endtask

  task automatic set_tx_empty(input logic v);
    if (!tx_fifo_empty_i && v) m_armed = 1'b1;
    tx_fifo_empty_i = v;
    @(posedge clk); #1;
  endtask

  function automatic int blen(input int dv, input int f, input int k);
    return dv + ((k + 1) * f) / (1 << FRAC_W) - (k * f) / (1 << FRAC_W);
  endfunction

  // Cycle 0 is the first cycle after the last divisor write.
  task automatic run_baud(input int dv, input int f, input int ncyc);
    int k = 0;
    int next_tick;
    int nt = 0;
    logic e;
    next_tick = (dv == 0) ? -1 : blen(dv, f, 0) - 1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = (c == next_tick);
      checks++;
      if (baud_out !== e) begin
        failures++;
        $display("FAIL baud dv=%0d f=%0d cycle=%0d: got %b expected %b", dv, f, c, baud_out, e);
      end
      if (e) begin
        nt++; k++;
        next_tick += blen(dv, f, k);
      end
    end
    @(posedge clk); #1;
    $display("baud dv=%0d f=%0d cycles=%0d ticks=%0d", dv, f, ncyc, nt);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({baud_out, irq_o, tx_push_o, rx_pop_o, tx_rst, rx_rst} !== 6'b0 || lcr_o !== 8'h03
        || rx_fifo_threshold !== CW'(1) || bus.dout_o !== 8'h00) begin
      failures++;
      $display("FAIL %s: got baud=%b irq=%b push=%b pop=%b txr=%b rxr=%b lcr=%02h thr=%0d dout=%02h expected lcr=03 thr=1 others 0",
               tag, baud_out, irq_o, tx_push_o, rx_pop_o, tx_rst, rx_rst, lcr_o, rx_fifo_threshold, bus.dout_o);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, e; logic p;
    bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.addr_i = 4'h0; bus.din_i = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_outputs");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 10; a++) begin
      host_read(4'(a), 4'h0, d, p, e);
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL reset_read addr=%0d: got %02h expected %02h", a, d, e);
      end
    end
  endtask

  task automatic test_regs();
    logic [7:0] d, e, v; logic p;
    logic [3:0] unm [8] = '{4'd4, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      host_write(4'd7, v);
      host_read(4'd7, 4'h0, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL scr_rw: got %02h expected %02h", d, e); end
      host_rw(4'd7, ~v, d, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL scr_simul_rw: got %02h expected %02h", d, e); end
    end
    host_write(4'd1, 8'($urandom) & 8'hF9);
    host_read(4'd1, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL ier_rw: got %02h expected %02h", d, e); end
    host_write(4'd1, 8'h00);
    foreach (unm[i]) begin
      host_write(unm[i], 8'($urandom));
      host_read(unm[i], 4'h0, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL unmapped addr=%0d: got %02h expected %02h", unm[i], d, e); end
    end
    host_read(4'd7, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL scr_after_unmapped: got %02h expected %02h", d, e); end
  endtask

  task automatic test_baud();
    logic [7:0] d, e; logic p;
    int dv, f;
    host_write(4'd3, 8'h83);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin dv = 4; f = 8; end
        1: begin dv = 1; f = 0; end
        2: begin dv = 0; f = 5; end
        default: begin dv = $urandom_range(1, 7); f = $urandom_range(0, 15); end
      endcase
      host_write(4'd0, 8'(dv));
      host_write(4'd1, 8'h00);
      host_write(4'd8, 8'(f));
      run_baud(dv, f, 40);
      host_read(4'd8, 4'h0, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL dlf_read: got %02h expected %02h", d, e); end
      host_read(4'd0, 4'h0, d, p, e);
      checks++;
      if (d !== e || p !== 1'b0) begin
        failures++;
        $display("FAIL dll_read: got %02h pop=%b expected %02h pop=0", d, p, e);
      end
    end
    host_write(4'd3, 8'h03);
  endtask

  task automatic test_rx_trigger();
    logic [7:0] d, e; logic p;
    logic [1:0] code;
    int cnt;
    host_write(4'd1, 8'h01);
    for (int i = 0; i < 10; i++) begin
      code = (i < 2) ? 2'd3 : 2'($urandom);
      cnt  = (i == 0) ? 14 : (i == 1) ? 13 : $urandom_range(0, D);
      host_write(4'd2, {code, 5'b0, 1'b1});
      rx_fifo_count_i = CW'(cnt);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (int'(rx_fifo_threshold) !== m_thresh()) begin
        failures++;
        $display("FAIL threshold code=%0d: got %0d expected %0d", code, rx_fifo_threshold, m_thresh());
      end
      checks++;
      if (irq_o !== (cnt >= m_thresh())) begin
        failures++;
        $display("FAIL irq_rx code=%0d count=%0d: got %b expected %b", code, cnt, irq_o, cnt >= m_thresh());
      end
      host_read(4'd2, 4'h0, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL iir_rx count=%0d: got %02h expected %02h", cnt, d, e); end
    end
    host_write(4'd1, 8'h00);
    host_write(4'd2, 8'h00);
    rx_fifo_count_i = '0;
  endtask

  task automatic test_lsr();
    logic [7:0] d, e; logic p;
    logic [3:0] err;
    logic [3:0] seq [4] = '{4'd5, 4'd9, 4'd9, 4'd5};
    host_read(4'd5, 4'h0, d, p, e);
    for (int i = 0; i < 6; i++) begin
      err = (i == 0) ? 4'b0010 : 4'($urandom_range(1, 15));
      set_tx_empty(1'($urandom));
      tx_idle_i = 1'($urandom);
      rx_fifo_empty_i = 1'($urandom);
      @(posedge clk); #1;
      host_read(4'd5, err, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL lsr_same_cycle err=%b: got %02h expected %02h", err, d, e); end
      foreach (seq[j]) begin
        host_read(seq[j], 4'h0, d, p, e);
        checks++;
        if (d !== e) begin failures++; $display("FAIL lsr_seq addr=%0d step=%0d: got %02h expected %02h", seq[j], j, d, e); end
      end
      host_read(4'd5, 4'h0, d, p, e);
      checks++;
      if (d !== e) begin failures++; $display("FAIL lsr_cleared: got %02h expected %02h", d, e); end
    end
    // Line status outranks RX data.
    rx_fifo_empty_i = 1'b1;
    host_write(4'd2, 8'h01);
    host_write(4'd1, 8'h05);
    rx_fifo_count_i = CW'(D);
    pulse_err(4'b0001);
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_priority_rls: got %02h expected %02h", d, e); end
    host_read(4'd5, 4'h0, d, p, e);
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_priority_rx: got %02h expected %02h", d, e); end
    host_write(4'd1, 8'h00);
    host_write(4'd2, 8'h00);
    rx_fifo_count_i = '0;
    set_tx_empty(1'b0);
    tx_idle_i = 1'b0;
  endtask

  task automatic test_thre();
    logic [7:0] d, e; logic p;
    host_write(4'd0, 8'h55);
    checks++;
    if (seen_push !== 1'b1) begin failures++; $display("FAIL thr_push: got %b expected 1", seen_push); end
    @(negedge clk);
    checks++;
    if (tx_push_o !== 1'b0) begin failures++; $display("FAIL thr_push_len: got %b expected 0", tx_push_o); end
    @(posedge clk); #1;
    host_write(4'd1, 8'h02);
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_not_armed: got %02h expected %02h", d, e); end
    set_tx_empty(1'b1);
    @(posedge clk); #1;
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_thre: got %b expected 1", irq_o); end
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_thre: got %02h expected %02h", d, e); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_thre_cleared: got %b expected 0", irq_o); end
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_reread: got %02h expected %02h", d, e); end
    // Enabling IER[1] while already empty arms the interrupt.
    host_write(4'd1, 8'h00);
    host_write(4'd1, 8'h02);
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_ier_arm: got %02h expected %02h", d, e); end
    host_write(4'd1, 8'h00);
    host_write(4'd1, 8'h02);
    host_write(4'd0, 8'($urandom));
    host_read(4'd2, 4'h0, d, p, e);
    checks++;
    if (d !== e) begin failures++; $display("FAIL iir_thr_write_clear: got %02h expected %02h", d, e); end
    host_write(4'd1, 8'h00);
    set_tx_empty(1'b0);
  endtask

  task automatic test_rbr();
    logic [7:0] d, e; logic p;
    rx_fifo_empty_i = 1'b1;
    rx_fifo_in = 8'hA5;
    host_read(4'd0, 4'h0, d, p, e);
    checks++;
    if (d !== e || p !== 1'b0) begin
      failures++;
      $display("FAIL rbr_empty: got %02h pop=%b expected %02h pop=0", d, p, e);
    end
    rx_fifo_empty_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_fifo_in = 8'($urandom);
      host_read(4'd0, 4'h0, d, p, e);
      checks++;
      if (d !== e || p !== 1'b1) begin
        failures++;
        $display("FAIL rbr_data: got %02h pop=%b expected %02h pop=1", d, p, e);
      end
    end
    rx_fifo_empty_i = 1'b1;
    host_write(4'd2, 8'h06);
    checks++;
    if (rx_rst !== 1'b1 || tx_rst !== 1'b1) begin
      failures++;
      $display("FAIL fifo_rst_pulse: got rx=%b tx=%b expected 1 1", rx_rst, tx_rst);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_rst !== 1'b0 || tx_rst !== 1'b0 || int'(rx_fifo_threshold) !== m_thresh()) begin
      failures++;
      $display("FAIL fifo_rst_len: got rx=%b tx=%b thr=%0d expected 0 0 %0d", rx_rst, tx_rst, rx_fifo_threshold, m_thresh());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    host_write(4'd3, 8'h83);
    host_write(4'd0, 8'h03);
    host_write(4'd1, 8'h00);
    host_write(4'd8, 8'h00);
    host_write(4'd7, 8'h3C);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (baud_out === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL reset_mid_wait: got no tick within 10 cycles expected a tick"); end
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("reset_mid");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_baud(0, 0, 12);
    host_write(4'd3, 8'h83);
    host_write(4'd0, 8'h03);
    run_baud(3, 0, 12);
    host_write(4'd3, 8'h03);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_baud();
    test_rx_trigger();
    test_lsr();
    test_thre();
    test_rbr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
